// File: rtl/morse_pkg.sv
// Shared types and threshold multipliers for the Morse key front end.
// Thresholds are expressed in Morse time units.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    CHAR_DONE
  } state_t;

  localparam int DASH_UNITS     = 2;
  localparam int CHAR_GAP_UNITS = 2;
  localparam int WORD_GAP_UNITS = 5;

endpackage

// File: rtl/morse_key_classifier_if.sv
// Key input and classified symbol pulses of the Morse key classifier.
// The master drives the raw key; the slave returns the symbol pulses.
interface morse_key_classifier_if;

  logic key_in;
  logic dot_inp;
  logic dash_inp;
  logic char_space_inp;
  logic word_space_inp;
  logic key_db;

  modport master (
    output key_in,
    input  dot_inp,
    input  dash_inp,
    input  char_space_inp,
    input  word_space_inp,
    input  key_db
  );

  modport slave (
    input  key_in,
    output dot_inp,
    output dash_inp,
    output char_space_inp,
    output word_space_inp,
    output key_db
  );

endinterface

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// dout follows din only after DEBOUNCE_CYCLES consecutive differing samples.
module morse_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          key_s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      key_s <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      s1    <= din;
      key_s <= s1;
      if (key_s == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        dout <= key_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_key_classifier.sv
// Times debounced key marks and gaps and emits registered single-cycle
// dot / dash / character-space / word-space pulses.
module morse_key_classifier
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 100,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int MIN_MARK_CYCLES = UNIT_CYCLES / 4
) (
  input logic                   clk,
  input logic                   rst,
  morse_key_classifier_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MARK_CYCLES);
  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_C = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             key_db;
  state_t           state, state_nxt;
  state_t           ret, ret_nxt;
  logic [CNT_W-1:0] mark_cnt, mark_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_nxt;
  logic             dot_q, dash_q, char_q, word_q;
  logic             dot_nxt, dash_nxt, char_nxt, word_nxt;

  morse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk (clk),
    .rst (rst),
    .din (bus.key_in),
    .dout(key_db)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ret      <= IDLE;
      mark_cnt <= '0;
      gap_cnt  <= '0;
      dot_q    <= 1'b0;
      dash_q   <= 1'b0;
      char_q   <= 1'b0;
      word_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ret      <= ret_nxt;
      mark_cnt <= mark_nxt;
      gap_cnt  <= gap_nxt;
      dot_q    <= dot_nxt;
      dash_q   <= dash_nxt;
      char_q   <= char_nxt;
      word_q   <= word_nxt;
    end
  end

  // Being in MARK tracks the key level, so edges are state/level mismatches.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    mark_nxt  = '0;
    gap_nxt   = gap_cnt;
    dot_nxt   = 1'b0;
    dash_nxt  = 1'b0;
    char_nxt  = 1'b0;
    word_nxt  = 1'b0;

    if (key_db) begin
      mark_nxt = (state == MARK) ? sat_inc(mark_cnt) : CNT_W'(1);
    end else begin
      gap_nxt = sat_inc(gap_cnt);
    end

    case (state)
      IDLE: begin
        if (key_db) begin
          ret_nxt   = IDLE;
          state_nxt = MARK;
        end
      end
      MARK: begin
        if (!key_db) begin
          if (mark_cnt < MIN_C) begin
            state_nxt = ret;
          end else begin
            dot_nxt   = (mark_cnt < DASH_C);
            dash_nxt  = !(mark_cnt < DASH_C);
            gap_nxt   = CNT_W'(1);
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (key_db) begin
          ret_nxt   = GAP;
          state_nxt = MARK;
        end else if (gap_nxt >= CHAR_C) begin
          char_nxt  = 1'b1;
          state_nxt = CHAR_DONE;
        end
      end
      CHAR_DONE: begin
        if (key_db) begin
          ret_nxt   = CHAR_DONE;
          state_nxt = MARK;
        end else if (gap_nxt >= WORD_C) begin
          word_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dot_inp        = dot_q;
  assign bus.dash_inp       = dash_q;
  assign bus.char_space_inp = char_q;
  assign bus.word_space_inp = word_q;
  assign bus.key_db         = key_db;

endmodule
